ifetch_queue: RTL and testbench

IFETCH_QUEUE -- requirements
Module: ifetch_queue

---
 rtl/ifetch_queue.sv | 115 +++++++++++
 tb/tb_ifetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential reads, buffers {instruction, pc} and
// streams them out on an AXI-Stream-like port. Optional counters under IFETCH_PERF_CNT_EN.
module ifetch_queue #(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic [PC_W-1:0]   jmp,
    input  logic              jmp_enable,
    output logic              axis_m_data_tvalid,
    input  logic              axis_m_data_tready,
    output logic [INST_W-1:0] axis_m_data_tdata,
    output logic [PC_W-1:0]   pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [15:0]       perf_flushed
`endif
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW:0]       count_reg;
    logic              pend_reg;
    logic [PC_W-1:0]   pend_addr_reg;
    logic [PC_W-1:0]   fetch_pc_reg;
    logic              run_reg;

    logic              empty;
    logic              pop;
    logic              push;

    assign empty = (count_reg == '0);
    assign pop   = !empty && axis_m_data_tready;
    // Data returning for a read issued before a jump is dropped here.
    assign push  = pend_reg && !jmp_enable;

    // Reserve a slot for every in-flight read so returning data always has room.
    assign imem_en   = run_reg && rst && !jmp_enable &&
                       ((count_reg + (AW + 1)'(pend_reg)) < DEPTH_L);
    assign imem_addr = fetch_pc_reg;

    assign axis_m_data_tvalid = !empty;
    assign axis_m_data_tdata  = empty ? '0 : inst_mem[rd_ptr_reg];
    assign pc                 = empty ? '0 : pc_mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            pend_reg      <= 1'b0;
            pend_addr_reg <= '0;
            fetch_pc_reg  <= RESET_PC;
            run_reg       <= 1'b0;
        end else begin
            run_reg       <= 1'b1;
            pend_reg      <= imem_en;
            pend_addr_reg <= fetch_pc_reg;
            if (jmp_enable) begin
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
                fetch_pc_reg <= {jmp[PC_W-1:2], 2'b00};
            end else begin
                if (imem_en) begin
                    fetch_pc_reg <= fetch_pc_reg + PC_W'(4);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            inst_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]   <= pend_addr_reg;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (jmp_enable && (perf_flushed != '1)) begin
                perf_flushed <= perf_flushed + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        jmp_enable;
    logic        tready;
    logic [15:0] jmp;
    logic        imem_en;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        tvalid;
    logic [31:0] tdata;
    logic [15:0] pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    ifetch_queue #(.PC_W(16), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_en           (imem_en),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .jmp               (jmp),
        .jmp_enable        (jmp_enable),
        .axis_m_data_tvalid(tvalid),
        .axis_m_data_tready(tready),
        .axis_m_data_tdata (tdata),
        .pc                (pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_flushed      (perf_flushed)
`endif
    );

    // Narrow-PC instance to exercise address wrap-around.
    logic        imem_en8;
    logic [7:0]  imem_addr8;
    logic [31:0] imem_rdata8;
    logic        tvalid8;
    logic [31:0] tdata8;
    logic [7:0]  pc8;
    logic [7:0]  jmp8 = 8'h00;
    logic        jmp_enable8 = 1'b0;
    logic        tready8 = 1'b1;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched8;
    logic [15:0] perf_flushed8;
`endif

    ifetch_queue #(.PC_W(8), .INST_W(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk               (clk),
        .rst               (rst),
        .imem_en           (imem_en8),
        .imem_addr         (imem_addr8),
        .imem_rdata        (imem_rdata8),
        .jmp               (jmp8),
        .jmp_enable        (jmp_enable8),
        .axis_m_data_tvalid(tvalid8),
        .axis_m_data_tready(tready8),
        .axis_m_data_tdata (tdata8),
        .pc                (pc8)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched      (perf_fetched8),
        .perf_flushed      (perf_flushed8)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [15:0] a);
        if (a == 16'h0000) return 32'h00E00113;
        if (a == 16'h0004) return 32'h00000013;
        return {~a, a};
    endfunction

    // Instruction memories: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        imem_rdata  <= imem_en  ? inst_of(imem_addr)   : 32'hDEADBEEF;
        imem_rdata8 <= imem_en8 ? {24'h0, imem_addr8}  : 32'hDEADBEEF;
    end

    // Reference model: queued pcs, reads awaiting data, next fetch address.
    logic [15:0] mq[$];
    logic [15:0] infl[$];
    logic [15:0] mfetch = 16'h0000;
    bit          started = 1'b0;
    int          m_fetched = 0;
    int          m_flushed = 0;
    bit          chk_on = 1'b0;
    int          en_count = 0;

    function automatic bit model_en();
        return started && rst && !jmp_enable && ((mq.size() + infl.size()) < DEPTH);
    endfunction

    function automatic logic [15:0] head_pc();
        return (mq.size() > 0) ? mq[0] : 16'h0000;
    endfunction

    always @(posedge clk) begin
        bit en;
        en = model_en();
        if (!rst) begin
            mq.delete();
            infl.delete();
            mfetch    = 16'h0000;
            started   = 1'b0;
            m_fetched = 0;
            m_flushed = 0;
        end else begin
            if (mq.size() > 0 && tready) begin
                void'(mq.pop_front());
                m_fetched++;
            end
            if (jmp_enable) begin
                mq.delete();
                infl.delete();
                mfetch = {jmp[15:2], 2'b00};
                m_flushed++;
            end else begin
                while (infl.size() > 0) mq.push_back(infl.pop_front());
                if (en) begin
                    infl.push_back(mfetch);
                    mfetch = mfetch + 16'd4;
                end
            end
            started = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            bit ev;
            ev = (mq.size() > 0);
            check_eq("imem_en", imem_en, model_en());
            if (model_en()) check_eq("imem_addr", imem_addr, mfetch);
            check_eq("tvalid", tvalid, ev);
            check_eq("pc", pc, head_pc());
            check_eq("tdata", tdata, ev ? inst_of(head_pc()) : 32'h0);
`ifdef IFETCH_PERF_CNT_EN
            check_eq("perf_fetched", perf_fetched, m_fetched);
            check_eq("perf_flushed", perf_flushed, m_flushed);
`endif
            if (imem_en) en_count++;
        end
    end

    logic [7:0] exp8 [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    int         n8 = 0;
    always @(negedge clk) begin
        if (chk_on && rst && tvalid8 && n8 < 4) begin
            check_eq("wrap_pc", pc8, exp8[n8]);
            check_eq("wrap_tdata", tdata8, {24'h0, exp8[n8]});
            n8++;
        end
    end

    task automatic step(input logic r, input logic je, input logic [15:0] j, input logic tr);
        rst        = r;
        jmp_enable = je;
        jmp        = j;
        tready     = tr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; jmp_enable = 1'b0; jmp = 16'h0; tready = 1'b1;
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset then stream with tready high.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

        // Backpressure: queue fills, issue stalls, head holds.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        en_count = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        check_eq("stall_reads", en_count, 4);
        check_eq("stall_head_pc", pc, 16'h0000);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

        // Jump while streaming.
        step(1'b1, 1'b1, 16'h0022, 1'b1);
        for (int i = 0; i < 10 && !tvalid; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
        check_eq("jmp_tvalid", tvalid, 1'b1);
        check_eq("jmp_pc", pc, 16'h0020);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

        // Back-to-back jumps: last target wins.
        step(1'b1, 1'b1, 16'h1000, 1'b0);
        step(1'b1, 1'b1, 16'h2003, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

        // Mid-operation reset with a simultaneous jump.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0100, 1'b1);
        check_eq("rst_mid_tvalid", tvalid, 1'b0);
        check_eq("rst_mid_pc", pc, 16'h0000);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b1);

`ifdef IFETCH_PERF_CNT_EN
        step(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b1, 16'h0040, 1'b0);
        step(1'b1, 1'b1, 16'h0080, 1'b0);
        check_eq("perf_fetched_7", perf_fetched, 32'd7);
        check_eq("perf_flushed_2", perf_flushed, 16'd2);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0,
                 16'($urandom), $urandom_range(0, 2) != 0);
        end

        check_eq("wrap_count", n8, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
